// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// One registered access per clock; read data is returned to the requester that issued it.
module sram_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         sram_address,
    output logic [DATA_WIDTH-1:0]         sram_write_data,
    input  logic [DATA_WIDTH-1:0]         sram_read_data,
    output logic                          sram_enable,
    output logic                          sram_write,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] owner;
    logic             owner_rd;
    logic             found;
    logic             accept;
    int               idx;

    // Search starts at rr_ptr and wraps, so the last winner gets lowest priority.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && found) req_ready[winner] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_next = IDLE;
        if (accept) state_next = ACCESS;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign sram_enable = (state == ACCESS);
    assign busy        = sram_enable;

    // Address and write data hold their last value when idle; only the write strobe drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_write      <= 1'b0;
            sram_address    <= '0;
            sram_write_data <= '0;
            rr_ptr          <= '0;
            owner           <= '0;
            owner_rd        <= 1'b0;
        end else if (accept) begin
            sram_write      <= req_write[winner];
            sram_address    <= req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            sram_write_data <= req_write_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            owner           <= winner;
            owner_rd        <= !req_write[winner];
            rr_ptr          <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else begin
            sram_write      <= 1'b0;
        end
    end

    // Read data is captured only at the end of a read access, never from an idle SRAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (state == ACCESS && owner_rd) begin
                rsp_valid[owner] <= 1'b1;
                rsp_data         <= sram_read_data;
            end
        end
    end

endmodule
